serial_adder: RTL and testbench

Bit-serial adder that sits directly upstream of the single-bit full adder cell. It accepts two WIDTH-bit operands plus a carry-in through a start/done handshake, and feeds one bit pair per clock, LSB first, through a full-adder slice with a registered carry. It returns the WIDTH-bit sum and the carry-out after a fixed latency. It trades WIDTH cycles of latency for a single full-adder slice of area.

---
 rtl/serial_adder_if.sv | 38 +++
 rtl/serial_adder.sv | 143 ++++++++++++++
 tb/tb_serial_adder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
//
// Purpose: start/done handshake and operand/result bundle for serial_adder.
//
// Signals:
//   start  master->slave  request pulse, sampled while busy=0
//   a, b   master->slave  WIDTH-bit operands, captured on accepted start
//   cin    master->slave  carry-in, captured on accepted start
//   busy   slave->master  addition in progress
//   done   slave->master  one-cycle pulse, sum/cout valid
//   sum    slave->master  WIDTH-bit result, held until next result
//   cout   slave->master  carry-out of bit WIDTH-1, held with sum
//   ovf    slave->master  signed overflow (only with SERIAL_ADDER_OVF_EN)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf signal.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Purpose: bit-serial adder. Captures two WIDTH-bit operands and a carry-in on
// an accepted start, then runs one full-adder slice per clock, LSB first, with
// a registered carry. After WIDTH RUN cycles the sum and carry-out are loaded
// into held output registers and done pulses for one cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   serial_adder_if.slave: start/a/b/cin in, busy/done/sum/cout(/ovf) out
//
// Parameters:
//   WIDTH  operand/sum width, 1..32
//
// Build option: define SERIAL_ADDER_OVF_EN to produce the signed-overflow
// output ovf (carry into MSB XOR carry out of MSB).
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_shift;

    // Full-adder slice on the current LSBs and the registered carry.
    assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    // A new request is taken whenever no addition is in flight, including the
    // DONE cycle, so back-to-back operations lose no cycle.
    assign w_accept = bus.start && (r_state != S_RUN);
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // Sum shift register with the new bit entering at the MSB. Written as a
    // shift plus bit overwrite so the same code holds for WIDTH=1.
    always_comb begin
        w_sum_shift            = r_sum_sr >> 1;
        w_sum_shift[WIDTH-1]   = w_s;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (w_last)   w_state_next = S_DONE;
            S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: all datapath registers are cleared on reset (not just the state),
    // so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_carry  <= bus.cin;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_sum_sr <= w_sum_shift;
            r_carry  <= w_c;
            r_cnt    <= r_cnt + CNT_W'(1);
            // Outputs are loaded only on the final bit, so partial sums never
            // appear on the port.
            if (w_last) begin
                r_sum  <= w_sum_shift;
                r_cout <= w_c;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // During the last RUN cycle r_carry is the carry into the MSB and w_c is
    // the carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Purpose: self-checking bench for serial_adder. Drives a WIDTH=8 instance
// from a table of directed vectors plus hand-written multi-cycle sequences
// (ignored re-start, asynchronous abort, back-to-back), and a WIDTH=1
// instance through the full-adder truth table.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk;
    logic rst;

    int total;
    int bad;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one 8-bit addition; samples at negedges. lat is the number of edges
    // after the accepting edge until done is seen (-1 on timeout); busy_n is
    // the number of sampled cycles with busy high before done.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                           output logic [7:0] s, output logic co, output logic ov,
                           output int lat, output int busy_n);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = c;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        lat    = -1;
        busy_n = 0;
        s      = '0;
        co     = 1'b0;
        ov     = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (bus8.busy) busy_n++;
            if (bus8.done) begin
                lat = k;
                s   = bus8.sum;
                co  = bus8.cout;
`ifdef SERIAL_ADDER_OVF_EN
                ov  = bus8.ovf;
`endif
                break;
            end
        end
    endtask

    logic [7:0] r_s;
    logic       r_co;
    logic       r_ov;
    int         lat;
    int         busy_n;
    int         done_n;
    int         done_k;
    int         done_k2;
    int         viol;
    logic       prev_done;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [2:0] iv;
    logic [1:0] exp1;

    initial begin
        total = 0;
        bad   = 0;

        //             a      b      cin   sum    cout  ovf
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};

        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.cin   = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus8.busy), 32'd0);
        check("reset_done", 32'(bus8.done), 32'd0);
        check("reset_sum",  32'(bus8.sum),  32'd0);
        check("reset_cout", 32'(bus8.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf",  32'(bus8.ovf),  32'd0);
`endif
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, r_s, r_co, r_ov, lat, busy_n);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
            check($sformatf("vec%0d_sum", i), 32'(r_s), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(r_co), 32'(vecs[i].cout));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(r_ov), 32'(vecs[i].ovf));
`endif
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), 32'(bus8.done), 32'd0);
        end

        // Start re-pulsed at E0+3 with other operands: must be ignored.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h0F;
        bus8.b     = 8'h01;
        bus8.cin   = 1'b0;
        @(posedge clk);
        done_n = 0;
        done_k = -1;
        s1     = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) bus8.start = 1'b0;
            if (k == 2) begin
                bus8.start = 1'b1;
                bus8.a     = 8'h55;
                bus8.b     = 8'h55;
                bus8.cin   = 1'b1;
            end
            if (k == 3) bus8.start = 1'b0;
            if (bus8.done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    s1     = bus8.sum;
                end
            end
        end
        check("repulse_done_count", 32'(done_n), 32'd1);
        check("repulse_done_edge",  32'(done_k), 32'd8);
        check("repulse_sum",        32'(s1),     32'h10);

        // Asynchronous reset mid-operation; the previous sum (0x10) must clear.
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hF0;
        bus8.b     = 8'h0F;
        bus8.cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus8.busy), 32'd0);
        check("abort_done", 32'(bus8.done), 32'd0);
        check("abort_sum",  32'(bus8.sum),  32'd0);
        check("abort_cout", 32'(bus8.cout), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        done_n = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus8.done) done_n++;
        end
        check("abort_no_done", 32'(done_n), 32'd0);
        run_op8(8'h12, 8'h34, 1'b0, r_s, r_co, r_ov, lat, busy_n);
        check("after_abort_sum",     32'(r_s), 32'h46);
        check("after_abort_latency", 32'(lat), 32'd8);

        // Back-to-back: start held high through the DONE cycle.
        @(negedge clk);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'h01;
        bus8.cin   = 1'b0;
        @(posedge clk);
        done_k    = -1;
        done_k2   = -1;
        done_n    = 0;
        viol      = 0;
        prev_done = 1'b0;
        s1        = '0;
        s2        = '0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus8.a = 8'h12;
                bus8.b = 8'h34;
            end
            if (k == 9) bus8.start = 1'b0;
            if (bus8.busy && bus8.done) viol++;
            if (prev_done && bus8.done) viol++;
            prev_done = bus8.done;
            if (bus8.done) begin
                done_n++;
                if (done_k < 0) begin
                    done_k = k;
                    s1     = bus8.sum;
                end else begin
                    done_k2 = k;
                    s2      = bus8.sum;
                end
            end
        end
        check("b2b_done_count",  32'(done_n),  32'd2);
        check("b2b_first_edge",  32'(done_k),  32'd8);
        check("b2b_second_edge", 32'(done_k2), 32'd17);
        check("b2b_first_sum",   32'(s1),      32'h00);
        check("b2b_second_sum",  32'(s2),      32'h46);
        check("b2b_protocol",    32'(viol),    32'd0);

        // WIDTH=1: full-adder truth table, done two edges after start.
        for (int i = 0; i < 8; i++) begin
            iv   = 3'(i);
            exp1 = 2'(iv[2]) + 2'(iv[1]) + 2'(iv[0]);
            @(negedge clk);
            bus1.start = 1'b1;
            bus1.a     = iv[2];
            bus1.b     = iv[1];
            bus1.cin   = iv[0];
            @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b0;
            check($sformatf("w1_%0d_busy", i), 32'(bus1.busy), 32'd1);
            check($sformatf("w1_%0d_early_done", i), 32'(bus1.done), 32'd0);
            @(negedge clk);
            check($sformatf("w1_%0d_done", i), 32'(bus1.done), 32'd1);
            check($sformatf("w1_%0d_sum", i),  32'(bus1.sum),  32'(exp1[0]));
            check($sformatf("w1_%0d_cout", i), 32'(bus1.cout), 32'(exp1[1]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
